// File: rtl/reservation_station_pkg.sv
// reservation_station_pkg: shared opcode encodings, sizes, entry/operand types and the CDB snoop helper
package reservation_station_pkg;
  localparam int RS_SIZE = 16;
  localparam int RS_WIDTH = 4;
  localparam int ROB_WIDTH = 4;
  localparam logic [6:0] ADD_type = 7'd1;
  localparam logic [6:0] SUB_type = 7'd2;
  localparam logic [6:0] AND_type = 7'd3;
  localparam logic [6:0] OR_type = 7'd4;
  localparam logic [6:0] XOR_type = 7'd5;
  localparam logic [6:0] SLL_type = 7'd6;
  localparam logic [6:0] SRL_type = 7'd7;
  localparam logic [6:0] SRA_type = 7'd8;
  localparam logic [6:0] SLT_type = 7'd9;
  localparam logic [6:0] SLTU_type = 7'd10;
  localparam logic [6:0] LUI_type = 7'd11;
  localparam logic [6:0] AUIPC_type = 7'd12;
  localparam logic [6:0] JAL_type = 7'd13;
  localparam logic [6:0] JALR_type = 7'd14;
  localparam logic [6:0] BEQ_type = 7'd15;
  localparam logic [6:0] BNE_type = 7'd16;
  localparam logic [6:0] BLT_type = 7'd17;
  localparam logic [6:0] BGE_type = 7'd18;
  typedef struct packed {
    logic busy;
    logic [31:0] v;
  } opnd_t;
  typedef struct packed {
    logic busy;
    logic [6:0] opcode;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] vj;
    logic qj_busy;
    logic [ROB_WIDTH-1:0] qj;
    logic [31:0] vk;
    logic qk_busy;
    logic [ROB_WIDTH-1:0] qk;
    logic [ROB_WIDTH-1:0] dest;
  } rs_entry_t;
  function automatic opnd_t snoop(
    input logic b, input logic [ROB_WIDTH-1:0] q, input logic [31:0] v,
    input logic av, input logic [ROB_WIDTH-1:0] at, input logic [31:0] ad,
    input logic lv, input logic [ROB_WIDTH-1:0] lt, input logic [31:0] ld
  );
    return (b && av && at == q) ? opnd_t'({1'b0, ad}) :
           (b && lv && lt == q) ? opnd_t'({1'b0, ld}) : opnd_t'({b, v});
  endfunction
endpackage

// File: rtl/reservation_station_rs_pick.sv
// rs_pick: lowest-index priority encoder; i_req request vector, o_found any set, o_idx lowest set index
module rs_pick #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] i_req,
  output logic         o_found,
  output logic [W-1:0] o_idx
);
  always_comb begin
    o_found = |i_req;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) o_idx = i_req[i] ? W'(i) : o_idx;
  end
endmodule

// File: rtl/reservation_station.sv
// reservation_station: holds issued ops until operands resolve via CDB snooping, dispatches lowest ready entry to registered alu_* outputs; rs_full flags no free entry
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clear,
  input  logic                 issue_valid,
  input  logic [6:0]           issue_opcode,
  input  logic [31:0]          issue_pc,
  input  logic [31:0]          issue_imm,
  input  logic [31:0]          issue_vj,
  input  logic                 issue_qj_busy,
  input  logic [ROB_WIDTH-1:0] issue_qj,
  input  logic [31:0]          issue_vk,
  input  logic                 issue_qk_busy,
  input  logic [ROB_WIDTH-1:0] issue_qk,
  input  logic [ROB_WIDTH-1:0] issue_dest,
  input  logic                 alu_cdb_valid,
  input  logic [ROB_WIDTH-1:0] alu_cdb_tag,
  input  logic [31:0]          alu_cdb_value,
  input  logic                 lsb_cdb_valid,
  input  logic [ROB_WIDTH-1:0] lsb_cdb_tag,
  input  logic [31:0]          lsb_cdb_value,
  output logic                 rs_full,
  output logic                 alu_en,
  output logic [6:0]           alu_opcode,
  output logic [31:0]          alu_pc,
  output logic [31:0]          alu_rs1,
  output logic [31:0]          alu_rs2,
  output logic [31:0]          alu_imm,
  output logic [ROB_WIDTH-1:0] alu_dest
);
  rs_entry_t r_ent [RS_SIZE];
  logic [RS_SIZE-1:0] w_busy, w_ready;
  logic w_disp_found, w_free_found;
  logic [RS_WIDTH-1:0] w_disp_idx, w_free_idx;
  opnd_t w_wj [RS_SIZE];
  opnd_t w_wk [RS_SIZE];
  opnd_t w_in_j, w_in_k;
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_busy[i] = r_ent[i].busy;
      w_ready[i] = r_ent[i].busy && !r_ent[i].qj_busy && !r_ent[i].qk_busy;
      w_wj[i] = snoop(r_ent[i].qj_busy, r_ent[i].qj, r_ent[i].vj, alu_cdb_valid, alu_cdb_tag,
                      alu_cdb_value, lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);
      w_wk[i] = snoop(r_ent[i].qk_busy, r_ent[i].qk, r_ent[i].vk, alu_cdb_valid, alu_cdb_tag,
                      alu_cdb_value, lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);
    end
  end
  assign w_in_j = snoop(issue_qj_busy, issue_qj, issue_vj, alu_cdb_valid, alu_cdb_tag,
                        alu_cdb_value, lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);
  assign w_in_k = snoop(issue_qk_busy, issue_qk, issue_vk, alu_cdb_valid, alu_cdb_tag,
                        alu_cdb_value, lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);
  assign rs_full = &w_busy;
  rs_pick #(.N(RS_SIZE), .W(RS_WIDTH)) u_pick_ready (
    .i_req(w_ready), .o_found(w_disp_found), .o_idx(w_disp_idx)
  );
  rs_pick #(.N(RS_SIZE), .W(RS_WIDTH)) u_pick_free (
    .i_req(~w_busy), .o_found(w_free_found), .o_idx(w_free_idx)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) r_ent[i] <= '0;
      alu_en <= 1'b0;
      alu_opcode <= '0;
      alu_pc <= '0;
      alu_rs1 <= '0;
      alu_rs2 <= '0;
      alu_imm <= '0;
      alu_dest <= '0;
    end else if (rdy) begin
      if (clear) begin
        for (int i = 0; i < RS_SIZE; i++) r_ent[i].busy <= 1'b0;
        alu_en <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          r_ent[i].qj_busy <= w_wj[i].busy;
          r_ent[i].vj <= w_wj[i].v;
          r_ent[i].qk_busy <= w_wk[i].busy;
          r_ent[i].vk <= w_wk[i].v;
        end
        alu_en <= w_disp_found;
        if (w_disp_found) begin
          alu_opcode <= r_ent[w_disp_idx].opcode;
          alu_pc <= r_ent[w_disp_idx].pc;
          alu_rs1 <= r_ent[w_disp_idx].vj;
          alu_rs2 <= r_ent[w_disp_idx].vk;
          alu_imm <= r_ent[w_disp_idx].imm;
          alu_dest <= r_ent[w_disp_idx].dest;
          r_ent[w_disp_idx].busy <= 1'b0;
        end
        // free slot comes from pre-dispatch state, so it never collides with the dispatched entry
        if (issue_valid && w_free_found)
          r_ent[w_free_idx] <= '{busy: 1'b1, opcode: issue_opcode, pc: issue_pc, imm: issue_imm,
                                 vj: w_in_j.v, qj_busy: w_in_j.busy, qj: issue_qj,
                                 vk: w_in_k.v, qk_busy: w_in_k.busy, qk: issue_qk,
                                 dest: issue_dest};
      end
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed and random stimulus checked every cycle against a behavioural model
module tb_reservation_station;
  import reservation_station_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rdy, clear, issue_valid, issue_qj_busy, issue_qk_busy;
  logic [6:0] issue_opcode;
  logic [31:0] issue_pc, issue_imm, issue_vj, issue_vk;
  logic [3:0] issue_qj, issue_qk, issue_dest;
  logic alu_cdb_valid, lsb_cdb_valid;
  logic [3:0] alu_cdb_tag, lsb_cdb_tag;
  logic [31:0] alu_cdb_value, lsb_cdb_value;
  logic rs_full, alu_en;
  logic [6:0] alu_opcode;
  logic [31:0] alu_pc, alu_rs1, alu_rs2, alu_imm;
  logic [3:0] alu_dest;
  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .issue_valid(issue_valid),
    .issue_opcode(issue_opcode), .issue_pc(issue_pc), .issue_imm(issue_imm),
    .issue_vj(issue_vj), .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj),
    .issue_vk(issue_vk), .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk),
    .issue_dest(issue_dest), .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag),
    .alu_cdb_value(alu_cdb_value), .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag),
    .lsb_cdb_value(lsb_cdb_value), .rs_full(rs_full), .alu_en(alu_en), .alu_opcode(alu_opcode),
    .alu_pc(alu_pc), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_dest(alu_dest)
  );
  typedef struct {
    logic busy;
    logic [6:0] op;
    logic [31:0] pc, imm, vj, vk;
    logic qjb, qkb;
    logic [3:0] qj, qk, dest;
  } ent_t;
  typedef struct {
    logic en;
    logic [6:0] op;
    logic [31:0] pc, rs1, rs2, imm;
    logic [3:0] dest;
  } out_t;
  ent_t m [16];
  ent_t n [16];
  out_t mo, no;
  int vectors = 0;
  int miscompares = 0;
  bit armed = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [32:0] res(input logic b, input logic [3:0] q, input logic [31:0] v);
    if (b && alu_cdb_valid && alu_cdb_tag == q) return {1'b0, alu_cdb_value};
    if (b && lsb_cdb_valid && lsb_cdb_tag == q) return {1'b0, lsb_cdb_value};
    return {b, v};
  endfunction
  task automatic model_next();
    int d, f;
    n = m;
    no = mo;
    d = -1;
    f = -1;
    if (rst) begin
      foreach (n[i]) n[i] = '{default: 0};
      no = '{default: 0};
    end else if (rdy && clear) begin
      foreach (n[i]) n[i].busy = 1'b0;
      no.en = 1'b0;
    end else if (rdy) begin
      foreach (m[i]) begin
        if (d < 0 && m[i].busy && !m[i].qjb && !m[i].qkb) d = i;
        if (f < 0 && !m[i].busy) f = i;
      end
      no.en = (d >= 0);
      if (d >= 0) begin
        no.op = m[d].op; no.pc = m[d].pc; no.rs1 = m[d].vj; no.rs2 = m[d].vk;
        no.imm = m[d].imm; no.dest = m[d].dest;
        n[d].busy = 1'b0;
      end
      foreach (m[i]) if (m[i].busy) begin
        {n[i].qjb, n[i].vj} = res(m[i].qjb, m[i].qj, m[i].vj);
        {n[i].qkb, n[i].vk} = res(m[i].qkb, m[i].qk, m[i].vk);
      end
      if (issue_valid && f >= 0) begin
        n[f].busy = 1'b1; n[f].op = issue_opcode; n[f].pc = issue_pc; n[f].imm = issue_imm;
        n[f].qj = issue_qj; n[f].qk = issue_qk; n[f].dest = issue_dest;
        {n[f].qjb, n[f].vj} = res(issue_qj_busy, issue_qj, issue_vj);
        {n[f].qkb, n[f].vk} = res(issue_qk_busy, issue_qk, issue_vk);
      end
    end
  endtask
  task automatic cyc();
    model_next();
    @(posedge clk);
    m = n;
    mo = no;
    #1;
  endtask
  always @(negedge clk) if (armed) begin
    logic full;
    full = 1'b1;
    foreach (m[i]) full &= m[i].busy;
    chk("rs_full", rs_full, full);
    chk("alu_en", alu_en, mo.en);
    chk("alu_opcode", alu_opcode, mo.op);
    chk("alu_pc", alu_pc, mo.pc);
    chk("alu_rs1", alu_rs1, mo.rs1);
    chk("alu_rs2", alu_rs2, mo.rs2);
    chk("alu_imm", alu_imm, mo.imm);
    chk("alu_dest", alu_dest, mo.dest);
  end
  task automatic idle();
    rst = 0; rdy = 1; clear = 0; issue_valid = 0; issue_opcode = 0; issue_pc = 0; issue_imm = 0;
    issue_vj = 0; issue_qj_busy = 0; issue_qj = 0; issue_vk = 0; issue_qk_busy = 0; issue_qk = 0;
    issue_dest = 0; alu_cdb_valid = 0; alu_cdb_tag = 0; alu_cdb_value = 0;
    lsb_cdb_valid = 0; lsb_cdb_tag = 0; lsb_cdb_value = 0;
  endtask
  task automatic issue(input logic [6:0] op, input logic [31:0] pc, input logic [31:0] vj,
                       input logic qjb, input logic [3:0] qj, input logic [31:0] vk,
                       input logic qkb, input logic [3:0] qk, input logic [3:0] dest);
    issue_valid = 1; issue_opcode = op; issue_pc = pc; issue_imm = pc + 32'h40;
    issue_vj = vj; issue_qj_busy = qjb; issue_qj = qj;
    issue_vk = vk; issue_qk_busy = qkb; issue_qk = qk; issue_dest = dest;
  endtask
  initial begin
    idle();
    rst = 1;
    cyc();
    armed = 1;
    cyc();
    rst = 0;
    chk("rst_en", alu_en, 0);
    chk("rst_full", rs_full, 0);
    chk("rst_rs1", alu_rs1, 0);
    issue(ADD_type, 32'h100, 5, 0, 0, 7, 0, 0, 3);
    cyc(); idle(); cyc();
    chk("add_en", alu_en, 1);
    chk("add_rs1", alu_rs1, 5);
    chk("add_rs2", alu_rs2, 7);
    chk("add_dest", alu_dest, 3);
    chk("add_op", alu_opcode, ADD_type);
    cyc();
    chk("add_en_drop", alu_en, 0);
    issue(SUB_type, 32'h104, 0, 1, 2, 1, 0, 0, 4);
    cyc(); idle(); cyc(); cyc();
    chk("sub_wait_en", alu_en, 0);
    alu_cdb_valid = 1; alu_cdb_tag = 2; alu_cdb_value = 10;
    cyc(); idle(); cyc();
    chk("sub_en", alu_en, 1);
    chk("sub_rs1", alu_rs1, 10);
    chk("sub_rs2", alu_rs2, 1);
    issue(ADD_type, 32'h108, 2, 0, 0, 0, 1, 6, 5);
    lsb_cdb_valid = 1; lsb_cdb_tag = 6; lsb_cdb_value = 32'h1234;
    cyc(); idle(); cyc();
    chk("fwd_en", alu_en, 1);
    chk("fwd_rs2", alu_rs2, 32'h1234);
    cyc();
    for (int k = 0; k < 16; k++) begin
      issue(ADD_type, 32'h200 + k, 0, 1, 9, k + 1, 0, 0, 4'(k));
      cyc();
    end
    idle();
    chk("fill_full", rs_full, 1);
    issue(OR_type, 32'h300, 1, 0, 0, 2, 0, 0, 4'hE);
    cyc(); idle(); cyc();
    chk("ignored_full", rs_full, 1);
    chk("ignored_en", alu_en, 0);
    alu_cdb_valid = 1; alu_cdb_tag = 9; alu_cdb_value = 99;
    cyc(); idle();
    for (int k = 0; k < 16; k++) begin
      cyc();
      chk("drain_en", alu_en, 1);
      chk("drain_dest", alu_dest, k);
      chk("drain_rs1", alu_rs1, 99);
      if (k == 0) chk("drain_full", rs_full, 0);
    end
    cyc();
    chk("drain_done_en", alu_en, 0);
    for (int k = 0; k < 3; k++) begin
      issue(XOR_type, 32'h400 + k, 0, 1, 1, 3, 0, 0, 4'(k));
      cyc();
    end
    issue(AND_type, 32'h410, 4, 0, 0, 4, 0, 0, 8);
    clear = 1;
    cyc(); idle();
    chk("clear_en", alu_en, 0);
    alu_cdb_valid = 1; alu_cdb_tag = 1; alu_cdb_value = 77;
    cyc(); idle(); cyc(); cyc();
    chk("clear_no_dispatch", alu_en, 0);
    issue(SLT_type, 32'h500, 32'h55, 0, 0, 32'h66, 0, 0, 7);
    cyc(); idle();
    rdy = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("hold_en", alu_en, 0);
    end
    rdy = 1;
    cyc();
    chk("rdy_en", alu_en, 1);
    chk("rdy_rs1", alu_rs1, 32'h55);
    issue(BEQ_type, 32'h600, 0, 1, 3, 0, 0, 0, 2);
    cyc(); idle();
    rst = 1;
    cyc(); rst = 0;
    chk("midrst_en", alu_en, 0);
    chk("midrst_rs1", alu_rs1, 0);
    chk("midrst_pc", alu_pc, 0);
    chk("midrst_full", rs_full, 0);
    repeat (4000) begin
      rst = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 49) == 0);
      issue_valid = ($urandom_range(0, 2) != 0) && !rs_full;
      issue_opcode = 7'($urandom); issue_pc = $urandom; issue_imm = $urandom;
      issue_vj = $urandom; issue_vk = $urandom;
      issue_qj_busy = $urandom_range(0, 1); issue_qk_busy = $urandom_range(0, 1);
      issue_qj = 4'($urandom); issue_qk = 4'($urandom); issue_dest = 4'($urandom);
      alu_cdb_valid = ($urandom_range(0, 2) == 0); alu_cdb_tag = 4'($urandom);
      alu_cdb_value = $urandom;
      lsb_cdb_valid = ($urandom_range(0, 2) == 0); lsb_cdb_tag = 4'($urandom);
      lsb_cdb_value = $urandom;
      cyc();
    end
    idle();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
